control_unit_framed: RTL and testbench

CONTROL_UNIT_FRAMED -- requirements
Module: control_unit_framed

---
 rtl/control_unit_framed.sv | 154 +++++++++++++++
 tb/tb_control_unit_framed.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/control_unit_framed.sv
// control_unit_framed: parses checksummed command frames from a byte stream into
// per-pipeline write/update strobes and returns a one-byte status per frame.
module control_unit_framed #(
    parameter int N_PIPELINES    = 2,
    parameter int N_BLOCKS       = 32,
    parameter int DATA_WIDTH     = 16,
    parameter int INSTR_WIDTH    = 32,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    in_byte,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [$clog2(N_BLOCKS)-1:0]   block_target,
    output logic [REG_ADDR_WIDTH-1:0]     reg_target,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic [INSTR_WIDTH-1:0]        instr_out,
    output logic [N_PIPELINES-1:0]        block_instr_write,
    output logic [N_PIPELINES-1:0]        block_reg_write,
    output logic [N_PIPELINES-1:0]        block_reg_update,
    output logic [N_PIPELINES-1:0]        alloc_sram_delay,
    output logic [N_PIPELINES-1:0]        reset_pipeline,
    output logic                          set_input_gain,
    output logic                          set_output_gain,
    output logic                          swap_pipelines,
    input  logic                          pipelines_swapping,
    output logic [7:0]                    resp_byte,
    output logic                          resp_valid,
    input  logic                          resp_ready
);
    localparam int BW = $clog2(N_BLOCKS);
    localparam int DB = DATA_WIDTH / 8;
    localparam int IB = INSTR_WIDTH / 8;

    typedef enum logic [3:0] {IDLE, BLOCK, REG, DATA, INSTR, CHECK, EXEC, SWAP_WAIT, RESP} state_t;

    state_t                  state;
    logic [3:0]              op;
    logic [3:0]              pipe;
    logic [7:0]              chk;
    logic [7:0]              cnt;
    logic [31:0]             tcnt;
    logic                    seen;
    logic                    accept;
    logic                    known;
    logic                    bad_pipe;
    logic [N_PIPELINES-1:0]  sel;

    assign in_ready = reset && (state inside {IDLE, BLOCK, REG, DATA, INSTR, CHECK});
    assign accept   = in_valid && in_ready;
    assign known    = in_byte[7:4] inside {[4'd1:4'd8]};
    assign bad_pipe = (in_byte[7:4] inside {[4'd1:4'd4], 4'd6}) && (32'(in_byte[3:0]) >= N_PIPELINES);
    assign sel      = N_PIPELINES'(1) << pipe;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            {op, pipe, chk, cnt, tcnt, seen} <= '0;
            {block_target, reg_target, data_out, instr_out, resp_byte, resp_valid} <= '0;
            {block_instr_write, block_reg_write, block_reg_update, alloc_sram_delay, reset_pipeline} <= '0;
            {set_input_gain, set_output_gain, swap_pipelines} <= '0;
        end else begin
            {block_instr_write, block_reg_write, block_reg_update, alloc_sram_delay, reset_pipeline} <= '0;
            {set_input_gain, set_output_gain, swap_pipelines} <= '0;
            case (state)
                IDLE: if (accept) begin
                    op   <= in_byte[7:4];
                    pipe <= in_byte[3:0];
                    chk  <= in_byte;
                    cnt  <= '0;
                    tcnt <= '0;
                    if (!known || bad_pipe) begin
                        resp_byte  <= known ? 8'h02 : 8'h01;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else
                        state <= (in_byte[7:4] <= 4'd3) ? BLOCK :
                                 (in_byte[7:4] inside {4'd5, 4'd6}) ? CHECK : DATA;
                end
                BLOCK, REG, DATA, INSTR, CHECK: begin
                    if (accept) begin
                        tcnt <= '0;
                        chk  <= chk ^ in_byte;
                        case (state)
                            BLOCK: begin
                                block_target <= in_byte[BW-1:0];
                                state        <= (op == 4'd1) ? INSTR : REG;
                            end
                            REG: begin
                                reg_target <= in_byte[REG_ADDR_WIDTH-1:0];
                                state      <= DATA;
                            end
                            DATA: begin
                                data_out <= DATA_WIDTH'({data_out, in_byte});
                                cnt      <= cnt + 8'd1;
                                if (cnt == 8'(DB - 1)) state <= CHECK;
                            end
                            INSTR: begin
                                instr_out <= INSTR_WIDTH'({instr_out, in_byte});
                                cnt       <= cnt + 8'd1;
                                if (cnt == 8'(IB - 1)) state <= CHECK;
                            end
                            default: if ((chk ^ in_byte) == 8'h00) begin
                                block_instr_write <= (op == 4'd1) ? sel : '0;
                                block_reg_write   <= (op == 4'd2) ? sel : '0;
                                block_reg_update  <= (op == 4'd3) ? sel : '0;
                                alloc_sram_delay  <= (op == 4'd4) ? sel : '0;
                                reset_pipeline    <= (op == 4'd6) ? sel : '0;
                                swap_pipelines    <= op == 4'd5;
                                set_input_gain    <= op == 4'd7;
                                set_output_gain   <= op == 4'd8;
                                state             <= EXEC;
                            end else begin
                                resp_byte  <= 8'h03;
                                resp_valid <= 1'b1;
                                state      <= RESP;
                            end
                        endcase
                    end else if (tcnt == 32'(TIMEOUT_CYCLES - 1)) begin
                        resp_byte  <= 8'h04;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else
                        tcnt <= tcnt + 32'd1;
                end
                EXEC: begin
                    seen <= 1'b0;
                    if (op == 4'd5)
                        state <= SWAP_WAIT;
                    else begin
                        resp_byte  <= 8'h00;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                // Completion needs a full rise-then-fall of pipelines_swapping.
                SWAP_WAIT: if (pipelines_swapping)
                    seen <= 1'b1;
                else if (seen) begin
                    resp_byte  <= 8'h00;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: if (resp_ready) begin
                    resp_valid <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_control_unit_framed.sv
// tb_control_unit_framed: directed frames with hand-computed expectations for
// strobes, latched fields, status codes, swap handshake, timeout and reset.
module tb_control_unit_framed;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  block_target;
    logic [3:0]  reg_target;
    logic [15:0] data_out;
    logic [31:0] instr_out;
    logic [1:0]  block_instr_write, block_reg_write, block_reg_update, alloc_sram_delay, reset_pipeline;
    logic        set_input_gain, set_output_gain, swap_pipelines;
    logic        pipelines_swapping = 1'b0;
    logic [7:0]  resp_byte;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [12:0] sv;
    logic [7:0]  fq[$];
    int          checks = 0;
    int          fails = 0;
    int          nstrobe = 0;
    int          multi = 0;

    control_unit_framed #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
        .block_target(block_target), .reg_target(reg_target), .data_out(data_out), .instr_out(instr_out),
        .block_instr_write(block_instr_write), .block_reg_write(block_reg_write),
        .block_reg_update(block_reg_update), .alloc_sram_delay(alloc_sram_delay),
        .reset_pipeline(reset_pipeline), .set_input_gain(set_input_gain),
        .set_output_gain(set_output_gain), .swap_pipelines(swap_pipelines),
        .pipelines_swapping(pipelines_swapping), .resp_byte(resp_byte), .resp_valid(resp_valid),
        .resp_ready(resp_ready)
    );

    always #5 clk = ~clk;

    assign sv = {block_instr_write, block_reg_write, block_reg_update, alloc_sram_delay,
                 reset_pipeline, set_input_gain, set_output_gain, swap_pipelines};

    always @(negedge clk) if (|sv) begin
        nstrobe++;
        if ($countones(sv) > 1) multi++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        in_byte  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        chk("in_ready_wait", n < 20, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic frame(input int force_chk);
        logic [7:0] x = 8'h00;
        foreach (fq[i]) begin x ^= fq[i]; send(fq[i]); end
        send(force_chk < 0 ? x : force_chk[7:0]);
    endtask

    task automatic get_resp(input logic [7:0] code);
        int n = 0;
        while (!resp_valid && n < 50) begin @(negedge clk); n++; end
        chk("resp_wait", n < 50, 1);
        chk("resp_byte", resp_byte, code);
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        chk("resp_drop", resp_valid, 0);
        chk("idle_ready", in_ready, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_strobes", sv, 0);
        chk("rst_data", data_out, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);

        // WRITE_REG pipe 1, block 5, reg 3, data 0x1234
        fq = '{8'h21, 8'h05, 8'h03, 8'h12, 8'h34};
        frame(-1);
        chk("wreg_strobe", sv, {2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 3'b000});
        chk("wreg_block", block_target, 5);
        chk("wreg_reg", reg_target, 3);
        chk("wreg_data", data_out, 16'h1234);
        get_resp(8'h00);
        chk("wreg_data_hold", data_out, 16'h1234);
        chk("wreg_count", nstrobe, 1);

        // WRITE_INSTR with a bad checksum
        fq = '{8'h10, 8'h07, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        frame(0);
        chk("badchk_strobe", sv, 0);
        get_resp(8'h03);
        chk("badchk_count", nstrobe, 1);

        fq = '{8'h11, 8'h1F, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
        frame(-1);
        chk("winstr_strobe", sv, {2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000});
        chk("winstr_block", block_target, 5'h1F);
        chk("winstr_instr", instr_out, 32'hCAFEF00D);
        get_resp(8'h00);

        // Unknown opcode and out-of-range pipe answer straight after the command byte
        send(8'h93);
        chk("unk_resp_now", resp_valid, 1);
        chk("unk_no_ready", in_ready, 0);
        get_resp(8'h01);
        send(8'h25);
        chk("badpipe_resp_now", resp_valid, 1);
        get_resp(8'h02);
        send(8'h62);
        get_resp(8'h02);
        chk("err_count", nstrobe, 2);

        fq = '{8'h50};
        frame(-1);
        chk("swap_strobe", sv, 13'h0001);
        repeat (3) @(negedge clk);
        chk("swap_wait_rise", resp_valid, 0);
        pipelines_swapping = 1'b1;
        repeat (10) @(negedge clk);
        chk("swap_wait_fall", resp_valid, 0);
        chk("swap_no_ready", in_ready, 0);
        pipelines_swapping = 1'b0;
        get_resp(8'h00);

        fq = '{8'h40, 8'h00, 8'h2A};
        frame(-1);
        chk("alloc_strobe", sv, {2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000});
        chk("alloc_data", data_out, 16'h002A);
        get_resp(8'h00);
        fq = '{8'h7F, 8'h13, 8'h57};
        frame(-1);
        chk("ingain_strobe", sv, 13'b100);
        chk("ingain_data", data_out, 16'h1357);
        get_resp(8'h00);
        fq = '{8'h8E, 8'h24, 8'h68};
        frame(-1);
        chk("outgain_strobe", sv, 13'b010);
        get_resp(8'h00);
        fq = '{8'h60};
        frame(-1);
        chk("rstpipe_strobe", sv, {2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000});
        get_resp(8'h00);
        chk("strobe_count", nstrobe, 7);

        // Timeout: 16 idle cycles after the command byte
        send(8'h41);
        repeat (15) @(negedge clk);
        chk("tmo_early", resp_valid, 0);
        @(negedge clk);
        chk("tmo_valid", resp_valid, 1);
        chk("tmo_code", resp_byte, 8'h04);
        in_byte  = 8'h55;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("tmo_hold_byte", resp_byte, 8'h04);
            chk("tmo_hold_valid", resp_valid, 1);
            chk("tmo_hold_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        get_resp(8'h04);
        chk("tmo_count", nstrobe, 7);

        // Reset in the middle of a WRITE_INSTR payload
        send(8'h11);
        send(8'h02);
        send(8'hAA);
        send(8'hBB);
        reset = 1'b0;
        #1;
        chk("mid_rst_block", block_target, 0);
        chk("mid_rst_reg", reg_target, 0);
        chk("mid_rst_data", data_out, 0);
        chk("mid_rst_instr", instr_out, 0);
        chk("mid_rst_resp", {resp_byte, resp_valid}, 0);
        chk("mid_rst_ready", in_ready, 0);
        chk("mid_rst_strobes", sv, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        fq = '{8'h31, 8'h0A, 8'h07, 8'hBE, 8'hEF};
        frame(-1);
        chk("upd_strobe", sv, {2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000});
        chk("upd_block", block_target, 5'h0A);
        chk("upd_reg", reg_target, 7);
        chk("upd_data", data_out, 16'hBEEF);
        get_resp(8'h00);
        chk("final_count", nstrobe, 8);
        chk("exclusive", multi, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
